store_merge_buffer: RTL and testbench

Parametrised store buffer between the MEM stage and the DCache write port. Each accepted store is converted into a lane-aligned byte-enable mask and data word. The store is queued in a DEPTH-entry FIFO and drained to the DCache over a valid/ready handshake. The buffer also answers same-cycle load-forwarding queries and, when compiled in, merges consecutive stores to the same aligned word. Supports SB/SH/SW/SWL/SWR on a data path DATA_WIDTH bits wide.

---
 rtl/store_merge_buffer.sv | 170 +++++++++++++++++
 tb/tb_store_merge_buffer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_buffer.sv
// Store buffer between MEM and the DCache write port: lane-aligns SB/SH/SW/SWL/SWR stores, queues them, forwards to loads.
// Optional merging of consecutive same-word stores is compiled in with `define STORE_BUF_MERGE_EN.
module store_merge_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [1:0]              in_size,
  input  logic [1:0]              in_lr,
  input  logic [31:0]             in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic [DATA_WIDTH/8-1:0] out_wen,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic [ADDR_WIDTH-1:0]   ld_addr,
  output logic [DATA_WIDTH/8-1:0] fwd_wen,
  output logic [DATA_WIDTH-1:0]   fwd_data,
  output logic                    empty
);
  localparam int BE    = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BE);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BE - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // source holds its payload stable while valid && !ready.

  logic [PTR_W-1:0]      head_ptr, tail_ptr;
  logic [CNT_W-1:0]      count;
  logic [DEPTH-1:0]      ent_valid;
  logic [ADDR_WIDTH-1:0] ent_addr [DEPTH];
  logic [BE-1:0]         ent_wen  [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data [DEPTH];

  logic [1:0]            b;
  logic [OFF-1:0]        wsel;
  logic [3:0]            wen4;
  logic [31:0]           d32, d32_m;
  logic                  discard;
  logic [BE-1:0]         new_wen;
  logic [DATA_WIDTH-1:0] new_data;
  logic [ADDR_WIDTH-1:0] in_aligned, ld_aligned;
  logic                  merge_hit, accept, alloc, merge, deq;

  assign b          = in_addr[1:0];
  assign wsel       = in_addr[OFF-1:0] >> 2;
  assign in_aligned = in_addr & ALIGN_MASK;
  assign ld_aligned = ld_addr & ALIGN_MASK;

  // Build the 4-byte pattern for the addressed word, lr first, then size.
  always_comb begin
    wen4    = 4'b0000;
    d32     = in_data;
    discard = 1'b0;
    if (in_lr == 2'b10) begin
      wen4 = 4'b1111 >> (~b);
      d32  = in_data >> {~b, 3'b000};
    end else if (in_lr == 2'b01) begin
      wen4 = 4'b1111 << b;
      d32  = in_data << {b, 3'b000};
    end else begin
      case (in_size)
        2'b00: wen4 = 4'b1111;
        2'b01: begin
          wen4 = b[1] ? 4'b1100 : 4'b0011;
          d32  = {2{in_data[15:0]}};
        end
        2'b10: begin
          wen4 = 4'b0001 << b;
          d32  = {4{in_data[7:0]}};
        end
        default: discard = 1'b1;
      endcase
    end
    for (int l = 0; l < 4; l++) d32_m[8*l +: 8] = wen4[l] ? d32[8*l +: 8] : 8'h00;
  end

  assign new_wen  = BE'(wen4) << {wsel, 2'b00};
  assign new_data = DATA_WIDTH'(d32_m) << {wsel, 5'b00000};

`ifdef STORE_BUF_MERGE_EN
  logic [PTR_W-1:0] youngest;
  assign youngest  = tail_ptr - PTR_W'(1);
  // The head may be mid-handshake with the DCache, so it is never modified.
  assign merge_hit = !discard && (count != '0) && ent_valid[youngest] &&
                     (ent_addr[youngest] == in_aligned) &&
                     !((youngest == head_ptr) && out_valid);
`else
  assign merge_hit = 1'b0;
`endif

  assign in_ready  = !rst && ((count < CNT_W'(DEPTH)) || merge_hit);
  assign accept    = in_valid && in_ready;
  assign alloc     = accept && !discard && !merge_hit;
  assign merge     = accept && merge_hit;
  assign out_valid = (count != '0);
  assign deq       = out_valid && out_ready;
  assign empty     = (count == '0);

  assign out_addr  = out_valid ? ent_addr[head_ptr] : '0;
  assign out_wen   = out_valid ? ent_wen[head_ptr]  : '0;
  assign out_data  = out_valid ? ent_data[head_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr  <= '0;
      tail_ptr  <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (deq) begin
        ent_valid[head_ptr] <= 1'b0;
        head_ptr            <= head_ptr + PTR_W'(1);
      end
      if (alloc) begin
        ent_valid[tail_ptr] <= 1'b1;
        tail_ptr            <= tail_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(alloc) - CNT_W'(deq);
    end
  end

  // Payload storage is qualified by ent_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc) begin
      ent_addr[tail_ptr] <= in_aligned;
      ent_wen[tail_ptr]  <= new_wen;
      ent_data[tail_ptr] <= new_data;
    end
`ifdef STORE_BUF_MERGE_EN
    else if (merge) begin
      ent_wen[youngest] <= ent_wen[youngest] | new_wen;
      for (int l = 0; l < BE; l++)
        if (new_wen[l]) ent_data[youngest][8*l +: 8] <= new_data[8*l +: 8];
    end
`endif
  end

  // Walk oldest to youngest so younger entries overwrite older bytes.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_wen  = '0;
    fwd_data = '0;
    idx      = head_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PTR_W'(i);
      if (ent_valid[idx] && (ent_addr[idx] == ld_aligned)) begin
        for (int l = 0; l < BE; l++) begin
          if (ent_wen[idx][l]) begin
            fwd_wen[l]         = 1'b1;
            fwd_data[8*l +: 8] = ent_data[idx][8*l +: 8];
          end
        end
      end
    end
  end

`ifndef STORE_BUF_MERGE_EN
  logic unused_merge;
  assign unused_merge = merge;
`endif

endmodule

// File: tb/tb_store_merge_buffer.sv
// Directed bench for store_merge_buffer: 32-bit instance for the main flow plus a 64-bit instance for lane placement.
module tb_store_merge_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [1:0]  in_size = '0;
  logic [1:0]  in_lr = '0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_addr;
  logic [3:0]  out_wen;
  logic [31:0] out_data;
  logic [31:0] ld_addr = '0;
  logic [3:0]  fwd_wen;
  logic [31:0] fwd_data;
  logic        empty;

  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [31:0] in_addr64 = '0;
  logic [1:0]  in_size64 = '0;
  logic [1:0]  in_lr64 = '0;
  logic [31:0] in_data64 = '0;
  logic        out_valid64;
  logic        out_ready64 = 1'b0;
  logic [31:0] out_addr64;
  logic [7:0]  out_wen64;
  logic [63:0] out_data64;
  logic [31:0] ld_addr64 = '0;
  logic [7:0]  fwd_wen64;
  logic [63:0] fwd_data64;
  logic        empty64;

  int n_cmp = 0;
  int n_err = 0;
  logic [67:0] exp_q[$];
  logic [67:0] exp_e;

  store_merge_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_size(in_size),
    .in_lr(in_lr), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_wen(out_wen), .out_data(out_data),
    .ld_addr(ld_addr), .fwd_wen(fwd_wen), .fwd_data(fwd_data), .empty(empty)
  );

  store_merge_buffer #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(4)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_addr(in_addr64), .in_size(in_size64),
    .in_lr(in_lr64), .in_data(in_data64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_addr(out_addr64),
    .out_wen(out_wen64), .out_data(out_data64),
    .ld_addr(ld_addr64), .fwd_wen(fwd_wen64), .fwd_data(fwd_data64), .empty(empty64)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: present a store and hold it until accepted (bounded)
  task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] lr,
                          input logic [31:0] d);
    int n;
    in_valid = 1'b1;
    in_addr  = a;
    in_size  = sz;
    in_lr    = lr;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check("store_accept", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  // scoreboard: compare the head against the oldest expected entry
  task automatic check_head(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_nonempty"}, 64'd0, 64'd1);
    end else begin
      exp_e = exp_q.pop_front();
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_addr"}, out_addr, exp_e[67:36]);
      check({tag, "_wen"}, out_wen, exp_e[35:32]);
      check({tag, "_data"}, out_data, exp_e[31:0]);
    end
  endtask

  initial begin
    int n;
    // reset state
    step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_wen", out_wen, 4'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_addr", out_addr, 32'h0);
    check("rst_fwd_wen", fwd_wen, 4'h0);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // SW with no combinational bypass
    in_valid = 1'b1; in_addr = 32'h1000; in_size = 2'b00; in_lr = 2'b00; in_data = 32'hDEADBEEF;
    check("sw_no_bypass", out_valid, 1'b0);
    step();
    in_valid = 1'b0;
    check("sw_out_valid", out_valid, 1'b1);
    check("sw_out_addr", out_addr, 32'h1000);
    check("sw_out_wen", out_wen, 4'hF);
    check("sw_out_data", out_data, 32'hDEADBEEF);
    check("sw_empty", empty, 1'b0);
    ld_addr = 32'h1002;
    #1;
    check("sw_fwd_wen", fwd_wen, 4'hF);
    check("sw_fwd_data", fwd_data, 32'hDEADBEEF);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("sw_drained", empty, 1'b1);

    // SWL then SWR to the same word; first is head so never merged
    do_store(32'h2002, 2'b00, 2'b10, 32'h11223344);
    do_store(32'h2002, 2'b00, 2'b01, 32'h55667788);
    exp_q.push_back({32'h2000, 4'b0111, 32'h00112233});
    exp_q.push_back({32'h2000, 4'b1100, 32'h77880000});
    ld_addr = 32'h2000;
    #1;
    check("lr_fwd_wen", fwd_wen, 4'hF);
    check("lr_fwd_data", fwd_data, 32'h77882233);
    check_head("swl");
    out_ready = 1'b1;
    step();
    check_head("swr");
    step();
    out_ready = 1'b0;
    check("lr_drained", empty, 1'b1);

    // fill with four SBs, fifth held until a dequeue
    do_store(32'h5000, 2'b10, 2'b00, 32'h01);
    do_store(32'h5011, 2'b10, 2'b00, 32'h02);
    do_store(32'h5022, 2'b10, 2'b00, 32'h03);
    do_store(32'h5033, 2'b10, 2'b00, 32'h04);
    exp_q.push_back({32'h5000, 4'b0001, 32'h00000001});
    exp_q.push_back({32'h5010, 4'b0010, 32'h00000200});
    exp_q.push_back({32'h5020, 4'b0100, 32'h00030000});
    exp_q.push_back({32'h5030, 4'b1000, 32'h04000000});
    check("full_in_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_addr = 32'h5040; in_size = 2'b10; in_lr = 2'b00; in_data = 32'h05;
    step();
    check("full_held", in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    check("full_deq_refuse", in_ready, 1'b0);
    check_head("sb0");
    step();
    out_ready = 1'b0;
    check("after_pulse_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    exp_q.push_back({32'h5040, 4'b0001, 32'h00000005});
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_head("sb_drain");
      step();
    end
    out_ready = 1'b0;
    check("sb_drained", empty, 1'b1);

    // discarded store (size 11) allocates nothing
    do_store(32'h6000, 2'b11, 2'b00, 32'hFFFFFFFF);
    check("discard_empty", empty, 1'b1);
    check("discard_out_valid", out_valid, 1'b0);

    // forwarding, youngest wins, same-cycle store not forwarded
    do_store(32'h3001, 2'b10, 2'b00, 32'h000000AB);
    do_store(32'h3002, 2'b01, 2'b00, 32'h0000CDEF);
    ld_addr = 32'h3000;
    #1;
    check("fwd_wen", fwd_wen, 4'hE);
    check("fwd_data", fwd_data, 32'hCDEFAB00);
    in_valid = 1'b1; in_addr = 32'h3000; in_size = 2'b10; in_lr = 2'b00; in_data = 32'h77;
    #1;
    check("fwd_same_cycle_wen", fwd_wen, 4'hE);
    step();
    in_valid = 1'b0;
    check("fwd_after_wen", fwd_wen, 4'hF);
    check("fwd_after_data", fwd_data, 32'hCDEFAB77);
    ld_addr = 32'h3004;
    #1;
    check("fwd_other_word", fwd_wen, 4'h0);
    out_ready = 1'b1;
    n = 0;
    while (!empty && n < 10) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    check("fwd_drained", empty, 1'b1);

    // 64-bit lane placement
    in_valid64 = 1'b1; in_addr64 = 32'h4006; in_size64 = 2'b01; in_lr64 = 2'b00; in_data64 = 32'h1234;
    check("w64_in_ready", in_ready64, 1'b1);
    step();
    in_valid64 = 1'b0;
    check("w64_out_addr", out_addr64, 32'h4000);
    check("w64_out_wen", out_wen64, 8'hC0);
    check("w64_out_data", out_data64, 64'h1234_0000_0000_0000);
    ld_addr64 = 32'h4003;
    #1;
    check("w64_fwd_wen", fwd_wen64, 8'hC0);
    check("w64_fwd_data", fwd_data64, 64'h1234_0000_0000_0000);

    // reset mid-transfer
    do_store(32'h7000, 2'b00, 2'b00, 32'hA0A0A0A0);
    do_store(32'h7100, 2'b00, 2'b00, 32'hB0B0B0B0);
    do_store(32'h7200, 2'b00, 2'b00, 32'hC0C0C0C0);
    out_ready = 1'b1;
    ld_addr = 32'h7000;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_empty", empty, 1'b1);
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_fwd_wen", fwd_wen, 4'h0);
    check("mid_rst_out_data", out_data, 32'h0);
    check("mid_rst_empty64", empty64, 1'b1);
    out_ready = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1'b1);
    check("rel_empty", empty, 1'b1);
    do_store(32'h8000, 2'b00, 2'b00, 32'h12345678);
    exp_q.push_back({32'h8000, 4'b1111, 32'h12345678});
    check_head("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
